// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared ALU: round-robin grant in IDLE, one op in flight.
// Latency: accept at edge N -> response valid in cycle N+2; a response stalls in RESP until consumed.
module alu_arbiter #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic [2:0]      req0_funct3,
  input  logic [6:0]      req0_funct7,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [XLEN-1:0] rsp0_result,
  output logic            rsp0_zero,

  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  input  logic [2:0]      req1_funct3,
  input  logic [6:0]      req1_funct7,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [XLEN-1:0] rsp1_result,
  output logic            rsp1_zero,

  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_funct3,
  output logic [6:0]      alu_funct7,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,

  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_last;
  logic            r_gnt;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [2:0]      r_funct3;
  logic [6:0]      r_funct7;
  logic [XLEN-1:0] r_result;
  logic            r_zero;

  logic            w_idle;
  logic            w_gnt;
  logic            w_accept;
  logic            w_done;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;

  assign w_idle = (r_state == IDLE);

  // On a tie the requester that did not complete last wins; otherwise whoever is asking.
  always_comb begin
    w_gnt = 1'b0;
    if (req0_valid && req1_valid) begin
      w_gnt = ~r_last;
    end else if (req1_valid) begin
      w_gnt = 1'b1;
    end
  end

  assign req0_ready = w_idle & req0_valid & ~w_gnt;
  assign req1_ready = w_idle & req1_valid & w_gnt;
  assign w_accept   = req0_ready | req1_ready;

  assign w_a      = w_gnt ? req1_a      : req0_a;
  assign w_b      = w_gnt ? req1_b      : req0_b;
  assign w_funct3 = w_gnt ? req1_funct3 : req0_funct3;
  assign w_funct7 = w_gnt ? req1_funct7 : req0_funct7;

  assign rsp0_valid  = (r_state == RESP) & ~r_gnt;
  assign rsp1_valid  = (r_state == RESP) & r_gnt;
  assign rsp0_result = r_result;
  assign rsp1_result = r_result;
  assign rsp0_zero   = r_zero;
  assign rsp1_zero   = r_zero;
  assign w_done      = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);

  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign alu_funct3 = r_funct3;
  assign alu_funct7 = r_funct7;

  assign busy = ~w_idle;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_last   <= 1'b1;
      r_gnt    <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_funct3 <= '0;
      r_funct7 <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a      <= w_a;
            r_b      <= w_b;
            r_funct3 <= w_funct3;
            r_funct7 <= w_funct7;
            r_gnt    <= w_gnt;
            r_state  <= EXEC;
          end
        end
        EXEC: begin
          r_result <= alu_result;
          r_zero   <= alu_zero;
          r_state  <= RESP;
        end
        RESP: begin
          // Pointer moves only on completion so an aborted op does not disturb fairness.
          if (w_done) begin
            r_last  <= r_gnt;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic against a queue-based reference.
module tb_alu_arbiter;
  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_zero;
  logic [XLEN-1:0] req0_a, req0_b, rsp0_result;
  logic [2:0]      req0_funct3;
  logic [6:0]      req0_funct7;
  logic            req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_zero;
  logic [XLEN-1:0] req1_a, req1_b, rsp1_result;
  logic [2:0]      req1_funct3;
  logic [6:0]      req1_funct7;
  logic [XLEN-1:0] alu_a, alu_b, alu_result;
  logic [2:0]      alu_funct3;
  logic [6:0]      alu_funct7;
  logic            alu_zero, busy;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic            id;
    logic [XLEN-1:0] res;
    logic            z;
    int              cyc;
  } exp_t;

  always #5 clk = ~clk;

  alu_arbiter #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_funct3(req0_funct3), .req0_funct7(req0_funct7),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_funct3(req1_funct3), .req1_funct7(req1_funct7),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
    .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
  );

  // RV64-style integer ALU: stands in for the shared ALU and serves as the reference for results.
  function automatic logic [XLEN-1:0] alu_f(input logic [2:0] f3, input logic [6:0] f7,
                                            input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    case (f3)
      3'd0: r = f7[5] ? a - b : a + b;
      3'd1: r = a << b[5:0];
      3'd2: r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      3'd3: r = {{(XLEN-1){1'b0}}, (a < b)};
      3'd4: r = a ^ b;
      3'd5: r = f7[5] ? XLEN'($signed(a) >>> b[5:0]) : a >> b[5:0];
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  assign alu_result = alu_f(alu_funct3, alu_funct7, alu_a, alu_b);
  assign alu_zero   = (alu_result == '0);

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0_valid = 0; req0_a = '0; req0_b = '0; req0_funct3 = '0; req0_funct7 = '0; rsp0_ready = 0;
    req1_valid = 0; req1_a = '0; req1_b = '0; req1_funct3 = '0; req1_funct7 = '0; rsp1_ready = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  // Drives one op for a single requester and reports what was seen; checks stay with the callers.
  task automatic run_op(input logic id, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        output int wait_c, output int lat, output logic [XLEN-1:0] res,
                        output logic z, output logic other);
    wait_c = -1; lat = -1; res = '0; z = 0; other = 0;
    if (id == 1'b0) begin
      req0_a = a; req0_b = b; req0_funct3 = f3; req0_funct7 = f7; req0_valid = 1; rsp0_ready = 1;
    end else begin
      req1_a = a; req1_b = b; req1_funct3 = f3; req1_funct7 = f7; req1_valid = 1; rsp1_ready = 1;
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if ((id == 1'b0 && req0_ready) || (id == 1'b1 && req1_ready)) begin
        wait_c = k;
        break;
      end
    end
    step();
    req0_valid = 0;
    req1_valid = 0;
    if (wait_c < 0) return;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      other = other | (id ? rsp0_valid : rsp1_valid);
      if (id ? rsp1_valid : rsp0_valid) begin
        lat = k;
        res = id ? rsp1_result : rsp0_result;
        z   = id ? rsp1_zero : rsp0_zero;
        break;
      end
    end
    step();
  endtask

  task automatic test_reset();
    clear_inputs();
    do_reset();
    @(negedge clk);
    tests++; if (rsp0_valid !== 1'b0) begin fails++; $display("FAIL rst_rsp0_valid: got %b expected 0", rsp0_valid); end
    tests++; if (rsp1_valid !== 1'b0) begin fails++; $display("FAIL rst_rsp1_valid: got %b expected 0", rsp1_valid); end
    tests++; if (rsp0_result !== '0 || rsp1_result !== '0) begin fails++; $display("FAIL rst_result: got %h/%h expected 0", rsp0_result, rsp1_result); end
    tests++; if (rsp0_zero !== 1'b0 || rsp1_zero !== 1'b0) begin fails++; $display("FAIL rst_zero: got %b/%b expected 0", rsp0_zero, rsp1_zero); end
    tests++; if ({alu_a, alu_b, alu_funct3, alu_funct7} !== '0) begin fails++; $display("FAIL rst_alu: got a=%h b=%h f3=%h f7=%h expected 0", alu_a, alu_b, alu_funct3, alu_funct7); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b expected 0", busy); end
    req0_valid = 1; req1_valid = 1;
    #1;
    tests++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin fails++; $display("FAIL rst_first_tie: got r0=%b r1=%b expected r0=1 r1=0", req0_ready, req1_ready); end
    req0_valid = 0; req1_valid = 0;
    step();
  endtask

  task automatic test_add_sub();
    int w, l; logic [XLEN-1:0] r; logic z, o;
    run_op(1'b0, 3'd0, 7'd0, 64'd5, 64'd3, w, l, r, z, o);
    tests++; if (w !== 0) begin fails++; $display("FAIL add_accept_wait: got %0d expected 0", w); end
    tests++; if (l !== 2) begin fails++; $display("FAIL add_latency: got %0d expected 2", l); end
    tests++; if (r !== 64'd8 || z !== 1'b0) begin fails++; $display("FAIL add_result: got %0d z=%b expected 8 z=0", r, z); end
    tests++; if (o !== 1'b0) begin fails++; $display("FAIL add_rsp1_valid: got %b expected 0", o); end
    run_op(1'b0, 3'd0, 7'h20, 64'd7, 64'd7, w, l, r, z, o);
    tests++; if (l !== 2) begin fails++; $display("FAIL sub_latency: got %0d expected 2", l); end
    tests++; if (r !== 64'd0 || z !== 1'b1) begin fails++; $display("FAIL sub_zero: got %0d z=%b expected 0 z=1", r, z); end
  endtask

  task automatic test_back_to_back();
    int gid[$]; int gcyc[$];
    clear_inputs();
    req0_a = 64'd10; req0_b = 64'd4; req0_valid = 1; rsp0_ready = 1;
    req1_a = 64'd9;  req1_b = 64'd9; req1_funct7 = 7'h20; req1_valid = 1; rsp1_ready = 1;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (req0_valid && req0_ready) begin gid.push_back(0); gcyc.push_back(k); end
      if (req1_valid && req1_ready) begin gid.push_back(1); gcyc.push_back(k); end
      if (rsp0_valid) begin
        tests++; if (rsp0_result !== 64'd14) begin fails++; $display("FAIL b2b_rsp0_result: got %0d expected 14", rsp0_result); end
      end
      if (rsp1_valid) begin
        tests++; if (rsp1_result !== 64'd0 || rsp1_zero !== 1'b1) begin fails++; $display("FAIL b2b_rsp1_result: got %0d z=%b expected 0 z=1", rsp1_result, rsp1_zero); end
      end
    end
    req0_valid = 0; req1_valid = 0;
    tests++;
    if (gid.size() < 4) begin
      fails++; $display("FAIL b2b_grant_count: got %0d expected >=4", gid.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++; if (gid[i] != i % 2) begin fails++; $display("FAIL b2b_grant_order[%0d]: got %0d expected %0d", i, gid[i], i % 2); end
        if (i > 0) begin
          tests++; if (gcyc[i] - gcyc[i-1] != 3) begin fails++; $display("FAIL b2b_interval[%0d]: got %0d expected 3", i, gcyc[i] - gcyc[i-1]); end
        end
      end
    end
    repeat (4) step();
  endtask

  task automatic test_stall();
    clear_inputs();
    req1_a = 64'd100; req1_b = 64'd23; req1_valid = 1;
    @(negedge clk);
    tests++; if (req1_ready !== 1'b1) begin fails++; $display("FAIL stall_accept: got %b expected 1", req1_ready); end
    step();
    req1_valid = 0;
    step();
    step();
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++; if (rsp1_valid !== 1'b1 || rsp1_result !== 64'd123) begin fails++; $display("FAIL stall_hold[%0d]: got v=%b res=%0d expected v=1 res=123", i, rsp1_valid, rsp1_result); end
      tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1 || rsp0_valid !== 1'b0) begin
        fails++; $display("FAIL stall_flags[%0d]: got r0=%b r1=%b busy=%b v0=%b expected 0 0 1 0", i, req0_ready, req1_ready, busy, rsp0_valid); end
      step();
    end
    rsp1_ready = 1;
    @(negedge clk);
    tests++; if (rsp1_valid !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      fails++; $display("FAIL stall_complete_cycle: got v1=%b r0=%b r1=%b expected 1 0 0", rsp1_valid, req0_ready, req1_ready); end
    step();
    @(negedge clk);
    tests++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin fails++; $display("FAIL stall_next_tie: got r0=%b r1=%b expected r0=1 r1=0", req0_ready, req1_ready); end
    req0_valid = 0; req1_valid = 0;
    step();
  endtask

  task automatic test_reset_in_resp();
    int w, l; logic [XLEN-1:0] r; logic z, o;
    clear_inputs();
    req0_a = 64'hF0; req0_b = 64'h0F; req0_funct3 = 3'd4; req0_valid = 1;
    step();
    req0_valid = 0;
    step();
    @(negedge clk);
    tests++; if (rsp0_valid !== 1'b1 || rsp0_result !== 64'hFF) begin fails++; $display("FAIL xor_before_rst: got v=%b res=%h expected v=1 res=ff", rsp0_valid, rsp0_result); end
    rst = 1; rsp0_ready = 1;
    step();
    rst = 0; rsp0_ready = 0;
    @(negedge clk);
    tests++; if (rsp0_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rst_abort: got v=%b busy=%b expected 0 0", rsp0_valid, busy); end
    tests++; if (rsp0_result !== '0 || rsp0_zero !== 1'b0 || alu_a !== '0 || alu_b !== '0) begin
      fails++; $display("FAIL rst_abort_regs: got res=%h z=%b a=%h b=%h expected 0", rsp0_result, rsp0_zero, alu_a, alu_b); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin fails++; $display("FAIL rst_abort_no_rsp[%0d]: got %b/%b expected 0", i, rsp0_valid, rsp1_valid); end
    end
    step();
    run_op(1'b0, 3'd0, 7'd0, 64'd1, 64'd2, w, l, r, z, o);
    tests++; if (w !== 0 || l !== 2 || r !== 64'd3) begin fails++; $display("FAIL post_rst_op: got wait=%0d lat=%0d res=%0d expected 0 2 3", w, l, r); end
  endtask

  task automatic test_repeat_req1();
    int w, l; logic [XLEN-1:0] r; logic z, o;
    run_op(1'b1, 3'd7, 7'd0, 64'hFF00, 64'h0FF0, w, l, r, z, o);
    tests++; if (r !== 64'h0F00 || o !== 1'b0) begin fails++; $display("FAIL req1_and: got res=%h other=%b expected f00 0", r, o); end
    run_op(1'b1, 3'd6, 7'd0, 64'hA, 64'h5, w, l, r, z, o);
    tests++; if (w !== 0) begin fails++; $display("FAIL req1_regrant_wait: got %0d expected 0", w); end
    tests++; if (l !== 2 || r !== 64'hF) begin fails++; $display("FAIL req1_or: got lat=%0d res=%h expected 2 f", l, r); end
  endtask

  task automatic test_random();
    exp_t q[$]; exp_t e;
    logic last, acc0, acc1, id;
    logic seen;
    int ncomp;
    clear_inputs();
    do_reset();
    last = 1; seen = 0; ncomp = 0;
    for (int c = 0; c < 600; c++) begin
      if (!req0_valid && $urandom_range(0, 2) == 0) begin
        req0_a = {$urandom, $urandom}; req0_b = {$urandom, $urandom};
        req0_funct3 = 3'($urandom_range(0, 7)); req0_funct7 = $urandom_range(0, 1) ? 7'h20 : 7'h00;
        if ($urandom_range(0, 3) == 0) req0_b = req0_a;
        req0_valid = 1;
      end
      if (!req1_valid && $urandom_range(0, 2) == 0) begin
        req1_a = {$urandom, $urandom}; req1_b = {$urandom, $urandom};
        req1_funct3 = 3'($urandom_range(0, 7)); req1_funct7 = $urandom_range(0, 1) ? 7'h20 : 7'h00;
        if ($urandom_range(0, 3) == 0) req1_b = req1_a;
        req1_valid = 1;
      end
      rsp0_ready = 1'($urandom_range(0, 1));
      rsp1_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      tests++; if (req0_ready && req1_ready) begin fails++; $display("FAIL rnd_ready_excl @%0d: both ready", c); end
      tests++; if (rsp0_valid && rsp1_valid) begin fails++; $display("FAIL rnd_rsp_excl @%0d: both valid", c); end
      if (acc0 || acc1) begin
        tests++; if (q.size() != 0) begin fails++; $display("FAIL rnd_accept_busy @%0d: got %0d outstanding expected 0", c, q.size()); end
        if (req0_valid && req1_valid) begin
          tests++; if (acc1 !== ~last) begin fails++; $display("FAIL rnd_tie_grant @%0d: got %0d expected %0d", c, acc1, ~last); end
        end
        e.id  = acc1;
        e.res = acc1 ? alu_f(req1_funct3, req1_funct7, req1_a, req1_b) : alu_f(req0_funct3, req0_funct7, req0_a, req0_b);
        e.z   = (e.res == '0);
        e.cyc = c;
        q.push_back(e);
      end
      if (rsp0_valid || rsp1_valid) begin
        id = rsp1_valid;
        tests++;
        if (q.size() == 0) begin
          fails++; $display("FAIL rnd_spurious_rsp @%0d: response with nothing outstanding", c);
        end else begin
          if (id !== q[0].id || (id ? rsp1_result : rsp0_result) !== q[0].res || (id ? rsp1_zero : rsp0_zero) !== q[0].z) begin
            fails++; $display("FAIL rnd_rsp @%0d: got id=%0d res=%h z=%b expected id=%0d res=%h z=%b", c, id,
                              id ? rsp1_result : rsp0_result, id ? rsp1_zero : rsp0_zero, q[0].id, q[0].res, q[0].z);
          end
          if (!seen) begin
            tests++; if (c - q[0].cyc != 2) begin fails++; $display("FAIL rnd_latency @%0d: got %0d expected 2", c, c - q[0].cyc); end
            seen = 1;
          end
          if (id ? rsp1_ready : rsp0_ready) begin
            last = id;
            void'(q.pop_front());
            seen = 0;
            ncomp++;
          end
        end
      end
      step();
      if (acc0) req0_valid = 0;
      if (acc1) req1_valid = 0;
    end
    tests++; if (ncomp < 20) begin fails++; $display("FAIL rnd_throughput: got %0d completions expected >=20", ncomp); end
    clear_inputs();
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_add_sub();
    test_back_to_back();
    test_stall();
    test_reset_in_resp();
    test_repeat_req1();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter XLEN, default 64, SHALL set the operand and result width.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-004 req0_valid  input  1  SHALL mean requester 0 presents an operation.
REQ-005 req0_ready  output  1  SHALL mean the arbiter accepts requester 0's operation this cycle.
REQ-006 req0_a, req0_b  input  XLEN each  SHALL be requester 0's operands.
REQ-007 req0_funct3  input  3, req0_funct7  input  7  SHALL be requester 0's ALU opcode fields.
REQ-008 rsp0_valid  output  1  SHALL mean a result for requester 0 is presented.
REQ-009 rsp0_ready  input  1  SHALL mean requester 0 consumes the result this cycle.
REQ-010 rsp0_result  output  XLEN, rsp0_zero  output  1  SHALL be the registered ALU result and zero flag.
REQ-011 req1_*/rsp1_* SHALL be identical in name pattern, direction and width to REQ-004..REQ-010, for requester 1.
REQ-012 alu_a, alu_b  output  XLEN; alu_funct3  output  3; alu_funct7  output  7  SHALL drive the shared ALU.
REQ-013 alu_result  input  XLEN, alu_zero  input  1  SHALL be the shared ALU's combinational outputs.
REQ-014 busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, EXEC, RESP.
REQ-016 IDLE: grant = requester with valid high; if both valid, the requester not granted last; ready asserted combinationally only to the granted requester.
REQ-017 At most one of req0_ready/req1_ready SHALL be high in any cycle; both SHALL be low outside IDLE.
REQ-018 On valid&ready in IDLE, operands, funct3, funct7 and grant id SHALL latch into internal registers; next state EXEC.
REQ-019 alu_a/alu_b/alu_funct3/alu_funct7 SHALL always be driven from the latched operand registers.
REQ-020 EXEC: alu_result and alu_zero SHALL be captured into the result registers at the clock edge; next state RESP.
REQ-021 RESP: rspN_valid high only for the granted requester N; result and zero held stable while rspN_ready low.
REQ-022 RESP with rspN_ready high: next state IDLE, last-grant pointer updated to N.
REQ-023 Latency: request accepted at edge of cycle N SHALL yield rspN_valid high in cycle N+2; minimum issue interval 3 cycles.
REQ-024 No new request SHALL be accepted in the cycle a response completes (IDLE entered one cycle later).
REQ-025 The arbiter SHALL not inspect or modify funct3/funct7/operand values; pass-through only.
REQ-026 The non-granted rspM_valid SHALL be 0 in all states.

Reset
REQ-027 With rst high at a clock edge: state IDLE, last-grant pointer = 1 (requester 0 wins first tie), operand/opcode/result registers 0, zero register 0.
REQ-028 After reset all outputs SHALL be: req*_ready per REQ-016, rsp*_valid 0, rsp*_result 0, rsp*_zero 0, alu_* 0, busy 0.
REQ-029 Reset in EXEC or RESP SHALL abort the operation; no response for it is ever presented.
REQ-030 rst SHALL take priority over every simultaneous handshake.

Verification
REQ-031 req0 ADD (funct3 000, funct7 0) a=5, b=3 at cycle N -> rsp0_valid cycle N+2, result 8, zero 0; rsp1_valid stays 0.
REQ-032 req0 SUB (funct7 0100000) a=7, b=7 -> rsp0_result 0, rsp0_zero 1.
REQ-033 Both valid from first cycle after reset, held high -> grants 0,1,0,1 across four operations, each 3 cycles apart.
REQ-034 rsp1_ready low 4 cycles in RESP -> rsp1_valid and result held constant, both req*_ready 0, busy 1.
REQ-035 rst pulsed during RESP of req0 XOR a=0xF0, b=0x0F -> next cycle rsp0_valid 0, busy 0, result registers 0; next request proceeds normally.
REQ-036 Only req1 valid after a req1 grant -> req1 granted again (no idle slot wasted on absent requester).
